// File: rtl/priority_index_decoder_if.sv
// Index-beat input stream and decoded-vector output stream of the priority index decoder.
interface priority_index_decoder_if #(
    parameter int INP_BIT = 8,
    parameter int OUT_BIT = $clog2(INP_BIT)
);
    logic               in_valid;
    logic               in_ready;
    logic [OUT_BIT-1:0] in_idx;
    logic               in_empty;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic [INP_BIT-1:0] out_vec;
    logic [OUT_BIT:0]   out_count;
    logic               out_err;

    modport master (
        output in_valid, in_idx, in_empty, in_last, out_ready,
        input  in_ready, out_valid, out_vec, out_count, out_err
    );

    modport slave (
        input  in_valid, in_idx, in_empty, in_last, out_ready,
        output in_ready, out_valid, out_vec, out_count, out_err
    );
endinterface

// File: rtl/priority_index_decoder.sv
// Rebuilds a bit vector from a frame of ascending bit indices, with set-bit count
// and an ordering/duplicate error flag. One output vector per in_last-terminated frame.
module priority_index_decoder #(
    parameter int INP_BIT = 8,
    parameter int OUT_BIT = $clog2(INP_BIT)
) (
    input  logic                    clk,
    input  logic                    rst,
    priority_index_decoder_if.slave bus
);
    typedef enum logic {ACCUM, HOLD} state_t;

    state_t             state_q, state_d;
    logic [INP_BIT-1:0] acc_q, acc_d;
    logic [OUT_BIT:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic [OUT_BIT-1:0] prev_q, prev_d;
    logic               prev_vld_q, prev_vld_d;
    logic               idx_ok;

    function automatic logic [INP_BIT-1:0] idx_to_bit(input logic [OUT_BIT-1:0] idx);
        idx_to_bit      = '0;
        idx_to_bit[idx] = 1'b1;
    endfunction

    // Indices past the vector width only exist when INP_BIT is not a power of two.
    assign idx_ok = (int'(bus.in_idx) < INP_BIT);

    assign bus.in_ready  = (state_q == ACCUM);
    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_vec   = (state_q == HOLD) ? acc_q : '0;
    assign bus.out_count = (state_q == HOLD) ? cnt_q : '0;
    assign bus.out_err   = (state_q == HOLD) ? err_q : 1'b0;

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        prev_d     = prev_q;
        prev_vld_d = prev_vld_q;
        case (state_q)
            ACCUM: begin
                if (bus.in_valid) begin
                    if (!bus.in_empty) begin
                        if (idx_ok) begin
                            acc_d = acc_q | idx_to_bit(bus.in_idx);
                            if (!acc_q[bus.in_idx])
                                cnt_d = cnt_q + (OUT_BIT+1)'(1);
                            if (prev_vld_q && (bus.in_idx <= prev_q))
                                err_d = 1'b1;
                            prev_d     = bus.in_idx;
                            prev_vld_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    if (bus.in_last)
                        state_d = HOLD;
                end
            end
            HOLD: begin
                // Frame state is cleared on the handoff edge so the next frame starts clean.
                if (bus.out_ready) begin
                    state_d    = ACCUM;
                    acc_d      = '0;
                    cnt_d      = '0;
                    err_d      = 1'b0;
                    prev_d     = '0;
                    prev_vld_d = 1'b0;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ACCUM;
            acc_q      <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
        end
    end
endmodule

// File: tb/tb_priority_index_decoder.sv
// Directed-vector bench for priority_index_decoder.
module tb_priority_index_decoder;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    priority_index_decoder_if #(.INP_BIT(8), .OUT_BIT(3)) bif ();

    priority_index_decoder #(.INP_BIT(8), .OUT_BIT(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send_beat(input logic [2:0] idx, input logic empty, input logic last);
        bif.in_valid = 1'b1;
        bif.in_idx   = idx;
        bif.in_empty = empty;
        bif.in_last  = last;
        @(posedge clk); #1;
        bif.in_valid = 1'b0;
        bif.in_empty = 1'b0;
        bif.in_last  = 1'b0;
    endtask

    task automatic consume();
        bif.out_ready = 1'b1;
        @(posedge clk); #1;
        bif.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({bif.out_valid, bif.out_vec, bif.out_count, bif.out_err} !== 14'h0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b vec=%h cnt=%0d err=%b, want all 0",
                     bif.out_valid, bif.out_vec, bif.out_count, bif.out_err);
        end
        checks++;
        if (bif.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", bif.in_ready);
        end
    endtask

    task automatic test_basic();
        send_beat(3'd0, 1'b0, 1'b0);
        send_beat(3'd3, 1'b0, 1'b0);
        checks++;
        if (bif.out_valid !== 1'b0 || bif.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_midframe: got valid=%b ready=%b want 0/1", bif.out_valid, bif.in_ready);
        end
        send_beat(3'd7, 1'b0, 1'b1);
        checks++;
        if ({bif.out_valid, bif.out_vec, bif.out_count, bif.out_err} !== {1'b1, 8'h89, 4'd3, 1'b0}) begin
            errors++;
            $display("FAIL basic_result: got valid=%b vec=%h cnt=%0d err=%b, want 1/89/3/0",
                     bif.out_valid, bif.out_vec, bif.out_count, bif.out_err);
        end
        checks++;
        if (bif.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_hold_ready: got %b want 0", bif.in_ready);
        end
        consume();
        checks++;
        if (bif.out_valid !== 1'b0 || bif.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_release: got valid=%b ready=%b want 0/1", bif.out_valid, bif.in_ready);
        end
    endtask

    task automatic test_empty_frame();
        send_beat(3'd6, 1'b1, 1'b1);
        checks++;
        if ({bif.out_valid, bif.out_vec, bif.out_count, bif.out_err} !== {1'b1, 8'h00, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL empty_frame: got valid=%b vec=%h cnt=%0d err=%b, want 1/00/0/0",
                     bif.out_valid, bif.out_vec, bif.out_count, bif.out_err);
        end
        consume();
    endtask

    task automatic test_duplicate();
        send_beat(3'd2, 1'b0, 1'b0);
        send_beat(3'd2, 1'b0, 1'b1);
        checks++;
        if ({bif.out_valid, bif.out_vec, bif.out_count, bif.out_err} !== {1'b1, 8'h04, 4'd1, 1'b1}) begin
            errors++;
            $display("FAIL duplicate: got valid=%b vec=%h cnt=%0d err=%b, want 1/04/1/1",
                     bif.out_valid, bif.out_vec, bif.out_count, bif.out_err);
        end
        consume();
        // Repeat that is not adjacent: count must not double-count bit 1.
        send_beat(3'd1, 1'b0, 1'b0);
        send_beat(3'd3, 1'b0, 1'b0);
        send_beat(3'd1, 1'b0, 1'b1);
        checks++;
        if ({bif.out_valid, bif.out_vec, bif.out_count, bif.out_err} !== {1'b1, 8'h0A, 4'd2, 1'b1}) begin
            errors++;
            $display("FAIL repeat_count: got valid=%b vec=%h cnt=%0d err=%b, want 1/0a/2/1",
                     bif.out_valid, bif.out_vec, bif.out_count, bif.out_err);
        end
        consume();
    endtask

    task automatic test_descending();
        send_beat(3'd6, 1'b0, 1'b0);
        send_beat(3'd4, 1'b0, 1'b1);
        checks++;
        if ({bif.out_valid, bif.out_vec, bif.out_count, bif.out_err} !== {1'b1, 8'h50, 4'd2, 1'b1}) begin
            errors++;
            $display("FAIL descending: got valid=%b vec=%h cnt=%0d err=%b, want 1/50/2/1",
                     bif.out_valid, bif.out_vec, bif.out_count, bif.out_err);
        end
        consume();
    endtask

    task automatic test_hold_stall();
        send_beat(3'd0, 1'b0, 1'b0);
        send_beat(3'd3, 1'b0, 1'b0);
        send_beat(3'd7, 1'b0, 1'b1);
        // Offer a beat during HOLD; it must not be taken.
        bif.in_valid = 1'b1;
        bif.in_idx   = 3'd1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({bif.out_valid, bif.out_vec, bif.out_count, bif.out_err, bif.in_ready} !==
                {1'b1, 8'h89, 4'd3, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL stall_cycle%0d: got valid=%b vec=%h cnt=%0d err=%b ready=%b, want 1/89/3/0/0",
                         i, bif.out_valid, bif.out_vec, bif.out_count, bif.out_err, bif.in_ready);
            end
        end
        bif.in_valid = 1'b0;
        consume();
        checks++;
        if (bif.in_ready !== 1'b1 || bif.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: got ready=%b valid=%b want 1/0", bif.in_ready, bif.out_valid);
        end
        send_beat(3'd5, 1'b0, 1'b1);
        checks++;
        if ({bif.out_valid, bif.out_vec, bif.out_count, bif.out_err} !== {1'b1, 8'h20, 4'd1, 1'b0}) begin
            errors++;
            $display("FAIL stall_next_frame: got valid=%b vec=%h cnt=%0d err=%b, want 1/20/1/0",
                     bif.out_valid, bif.out_vec, bif.out_count, bif.out_err);
        end
        consume();
    endtask

    task automatic test_reset_midframe();
        send_beat(3'd5, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        send_beat(3'd1, 1'b0, 1'b1);
        checks++;
        if ({bif.out_valid, bif.out_vec, bif.out_count, bif.out_err} !== {1'b1, 8'h02, 4'd1, 1'b0}) begin
            errors++;
            $display("FAIL reset_midframe: got valid=%b vec=%h cnt=%0d err=%b, want 1/02/1/0",
                     bif.out_valid, bif.out_vec, bif.out_count, bif.out_err);
        end
        // Reset while holding drops the pending frame.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({bif.out_valid, bif.out_vec, bif.out_count, bif.out_err, bif.in_ready} !==
            {1'b0, 8'h00, 4'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_in_hold: got valid=%b vec=%h cnt=%0d err=%b ready=%b, want 0/00/0/0/1",
                     bif.out_valid, bif.out_vec, bif.out_count, bif.out_err, bif.in_ready);
        end
    endtask

    task automatic test_back_to_back();
        send_beat(3'd1, 1'b0, 1'b0);
        send_beat(3'd2, 1'b0, 1'b1);
        checks++;
        if ({bif.out_valid, bif.out_vec, bif.out_count, bif.out_err} !== {1'b1, 8'h06, 4'd2, 1'b0}) begin
            errors++;
            $display("FAIL b2b_first: got valid=%b vec=%h cnt=%0d err=%b, want 1/06/2/0",
                     bif.out_valid, bif.out_vec, bif.out_count, bif.out_err);
        end
        consume();
        // Empty beats around a real index; prev cleared so idx 0 is not an ordering error.
        send_beat(3'd7, 1'b1, 1'b0);
        send_beat(3'd0, 1'b0, 1'b0);
        send_beat(3'd0, 1'b1, 1'b0);
        send_beat(3'd4, 1'b0, 1'b0);
        send_beat(3'd2, 1'b1, 1'b1);
        checks++;
        if ({bif.out_valid, bif.out_vec, bif.out_count, bif.out_err} !== {1'b1, 8'h11, 4'd2, 1'b0}) begin
            errors++;
            $display("FAIL b2b_second: got valid=%b vec=%h cnt=%0d err=%b, want 1/11/2/0",
                     bif.out_valid, bif.out_vec, bif.out_count, bif.out_err);
        end
        consume();
        for (int i = 0; i < 8; i++)
            send_beat(3'(i), 1'b0, (i == 7));
        checks++;
        if ({bif.out_valid, bif.out_vec, bif.out_count, bif.out_err} !== {1'b1, 8'hFF, 4'd8, 1'b0}) begin
            errors++;
            $display("FAIL full_vector: got valid=%b vec=%h cnt=%0d err=%b, want 1/ff/8/0",
                     bif.out_valid, bif.out_vec, bif.out_count, bif.out_err);
        end
        consume();
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bif.in_valid  = 1'b0;
        bif.in_idx    = '0;
        bif.in_empty  = 1'b0;
        bif.in_last   = 1'b0;
        bif.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_empty_frame();
        test_duplicate();
        test_descending();
        test_hold_stall();
        test_reset_midframe();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
